spike_rate_encoder: RTL and testbench
=====================================

Name: spike_rate_encoder

Overview:
- Converts a signed multi-bit value into a rate-coded spike train over a programmable number of timesteps.
- It is the inverse of the threshold-plus-spike-accumulator path: that path turns spikes into a count; this block turns a value into spikes.
- It sits at the input edge of the spiking array. It feeds one row with one spike per timestep, and its cadence is set by a shared timestep strobe.

Parameters:
- DATA_WIDTH, 16: width of input value and threshold (signed, two's complement).
- STEP_WIDTH, 8: width of the timestep count and the emitted-spike count.

Ports:
- clk, input, 1: clock, rising edge.
- rstn, input, 1: synchronous active-low reset.
- in_valid, input, 1: a new value/threshold/length triple is offered.
- in_ready, output, 1: encoder can accept a triple.
- in_value, input, DATA_WIDTH: signed value to encode.
- threshold, input, DATA_WIDTH: signed firing threshold.
- num_steps, input, STEP_WIDTH: train length in timesteps.
- step_en, input, 1: advance one timestep (global strobe).
- flush, input, 1: abort the current train.
- spike, output, 1: spike for the completed timestep; qualified by spike_valid.
- spike_valid, output, 1: one-cycle pulse per executed timestep.
- busy, output, 1: a train is in progress.
- done, output, 1: one-cycle pulse at the end of a train.
- spike_count, output, STEP_WIDTH: number of spikes emitted in the current or last train.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - State goes to IDLE; accumulator and step counter go to 0.
  - spike, spike_valid, done, busy, spike_count all go to 0; in_ready=1.
  - Reset overrides flush, accept and step_en, including mid-train.
- State machine IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid&&in_ready, latch the operands and apply these clamps:
    - thr = max(threshold, 1).
    - v = clamp(in_value, 0, thr). Negative values give no spikes; values at or above thr spike every step.
  - Also on accept: N = num_steps; acc=0, step=0, spike_count=0.
  - Next state is RUN if N!=0. If N==0, next state is DONE with no spike_valid.
- RUN:
  - in_ready=0, busy=1. step_en is sampled each cycle; with step_en=0 the state holds.
  - On step_en: sum = acc + v, computed at DATA_WIDTH+1 bits (cannot overflow because acc<thr and v<=thr).
    - If sum >= thr: spike<=1, acc<=sum-thr, spike_count<=spike_count+1.
    - Otherwise: spike<=0, acc<=sum.
    - In both cases spike_valid<=1 and step<=step+1.
  - Output timing: spike and spike_valid are visible in the cycle after the step_en cycle.
  - Spike rate: at most one spike per timestep. Invariant 0<=acc<thr. Total spikes = floor(N*v/thr).
  - Last step: when step+1==N on a step_en, the same edge also sets done<=1 and state<=DONE. The last spike_valid and done are coincident.
- DONE:
  - in_ready=0, busy=0.
  - Lasts exactly one cycle (done=1), then IDLE.
  - For N==0, done pulses the cycle after accept.
- spike_valid and done are single-cycle pulses; spike is 0 whenever spike_valid=0.
- spike_count holds its value after DONE until the next accept.
- flush:
  - In RUN or DONE: next state IDLE, done not asserted, spike_valid<=0.
  - spike_count and acc are frozen at their current values.
  - flush has priority over step_en.
  - In IDLE, flush blocks the accept in that cycle.
- in_valid while in_ready=0 is ignored; no queueing. The source must hold in_valid until accepted.

Test Plan:
- Basic rate: v=3, thr=10, N=10, step_en every cycle -> spike_valid 10 pulses with spikes at steps 4, 7, 10; done coincides with the 10th spike_valid; spike_count=3; in_ready=1 two cycles after the last step_en.
- Clamps:
  - v=-5, thr=10, N=4 -> 4 spike_valid, 0 spikes.
  - v=50, thr=10, N=4 -> 4 spikes.
  - thr=0, v=1, N=3 -> 3 spikes (thr forced to 1).
- Gapped strobe: v=5, thr=10, N=4, step_en every 3rd cycle -> spikes at steps 2 and 4 only; state holds between strobes; spike_count=2.
- Zero length: N=0 accept -> no spike_valid, done 1 cycle after accept, in_ready back the following cycle.
- Abort: flush asserted after step 3 of an N=10 train, same cycle as step_en -> no further spike_valid, no done, IDLE next cycle, spike_count frozen. rstn low mid-train -> all outputs 0 and in_ready=1 after the reset edge.
- Back-to-back: hold in_valid high with two triples -> second accepted exactly one cycle after the first train's DONE cycle; acc restarts from 0 (first step with v=9, thr=10 gives no spike).

Source files
------------

// File: rtl/spike_rate_encoder_if.sv
// Operand hand-off bundle for spike_rate_encoder.
//
// A source offers a {value, threshold, length} triple with in_valid and holds
// it until the encoder raises in_ready; the transfer happens on the rising
// edge where both are high.
//
// Signals:
//   in_valid  - source has a triple on the bus
//   in_ready  - encoder can take a triple this cycle
//   in_value  - signed value to encode (two's complement)
//   threshold - signed firing threshold (two's complement)
//   num_steps - train length in timesteps
//
// Modports:
//   master - the producer of triples
//   slave  - the encoder
interface spike_rate_encoder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_value;
  logic signed [DATA_WIDTH-1:0] threshold;
  logic [STEP_WIDTH-1:0]        num_steps;

  modport master (
    output in_valid, in_value, threshold, num_steps,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_value, threshold, num_steps,
    output in_ready
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns a signed value into a spike train of num_steps
// timesteps. It emits floor(N*v/thr) spikes, at most one per timestep, spread
// evenly by an accumulate-and-subtract scheme. Timesteps advance on the shared
// step_en strobe, so one encoder can drive one row of the spiking array in
// lock-step with its neighbours.
//
// Ports:
//   clk         - clock, rising edge
//   rstn        - synchronous active-low reset
//   bus         - slave side of the operand hand-off (valid/ready triple)
//   step_en     - advance one timestep
//   flush       - abort the current train (also blocks an accept in IDLE)
//   spike       - spike of the timestep just executed, qualified by spike_valid
//   spike_valid - one-cycle pulse per executed timestep
//   busy        - a train is in progress
//   done        - one-cycle pulse when a train completes
//   spike_count - spikes emitted in the current or most recent train
//
// DATA_WIDTH/STEP_WIDTH must match the parameters of the connected interface.
module spike_rate_encoder #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  spike_rate_encoder_if.slave   bus,
  input  logic                  step_en,
  input  logic                  flush,
  output logic                  spike,
  output logic                  spike_valid,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_WIDTH-1:0] spike_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_t                  state;
  logic                    ready_q;
  logic [DATA_WIDTH-1:0]   thr_q;
  logic [DATA_WIDTH-1:0]   v_q;
  logic [DATA_WIDTH-1:0]   acc;
  logic [STEP_WIDTH-1:0]   n_q;
  logic [STEP_WIDTH-1:0]   step;

  // Operand clamps. After clamping both thr and v are non-negative with
  // thr >= 1 and v <= thr, so the datapath below can work unsigned.
  logic signed [DATA_WIDTH-1:0] thr_clamped;
  logic signed [DATA_WIDTH-1:0] v_clamped;

  always_comb begin
    thr_clamped = (bus.threshold < ONE) ? ONE : bus.threshold;
    if (bus.in_value < 0)
      v_clamped = '0;
    else if (bus.in_value > thr_clamped)
      v_clamped = thr_clamped;
    else
      v_clamped = bus.in_value;
  end

  // One extra bit on the sum: acc < thr and v <= thr, so acc + v < 2*thr
  // always fits and the subtract-on-fire result fits back in DATA_WIDTH.
  logic [DATA_WIDTH:0]   sum;
  logic                  fire;
  logic [STEP_WIDTH-1:0] next_step;

  always_comb begin
    sum       = {1'b0, acc} + {1'b0, v_q};
    fire      = (sum >= {1'b0, thr_q});
    next_step = step + 1'b1;
  end

  assign bus.in_ready = ready_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      spike       <= 1'b0;
      spike_valid <= 1'b0;
      spike_count <= '0;
      acc         <= '0;
      step        <= '0;
      thr_q       <= ONE;
      v_q         <= '0;
      n_q         <= '0;
    end else begin
      // Pulses default low so they last exactly one cycle.
      spike       <= 1'b0;
      spike_valid <= 1'b0;
      done        <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.in_valid && ready_q && !flush) begin
            thr_q       <= thr_clamped;
            v_q         <= v_clamped;
            n_q         <= bus.num_steps;
            acc         <= '0;
            step        <= '0;
            spike_count <= '0;
            ready_q     <= 1'b0;
            // A zero-length train goes straight to the completion pulse.
            if (bus.num_steps == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (flush) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end else if (step_en) begin
            spike_valid <= 1'b1;
            step        <= next_step;
            if (fire) begin
              spike       <= 1'b1;
              acc         <= DATA_WIDTH'(sum - {1'b0, thr_q});
              spike_count <= spike_count + 1'b1;
            end else begin
              acc <= DATA_WIDTH'(sum);
            end
            // The last timestep's spike_valid and done land together.
            if (next_step == n_q) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          busy    <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: a table of whole-train vectors,
// hand-written multi-cycle sequences (zero length, flush, reset, back-to-back)
// and a randomized run compared cycle by cycle against a rate-formula model.
module tb_spike_rate_encoder;

  localparam int DW = 16;
  localparam int SW = 8;

  logic          clk;
  logic          rstn;
  logic          step_en;
  logic          flush;
  logic          spike;
  logic          spike_valid;
  logic          busy;
  logic          done;
  logic [SW-1:0] spike_count;

  spike_rate_encoder_if #(.DATA_WIDTH(DW), .STEP_WIDTH(SW)) bus ();

  spike_rate_encoder #(.DATA_WIDTH(DW), .STEP_WIDTH(SW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .step_en     (step_en),
    .flush       (flush),
    .spike       (spike),
    .spike_valid (spike_valid),
    .busy        (busy),
    .done        (done),
    .spike_count (spike_count)
  );

  int n_compared = 0;
  int n_failed   = 0;

  typedef struct {
    int          value;
    int          thr;
    int          n;
    int          gap;
    logic [15:0] exp_pat;
    int          exp_count;
  } vec_t;

  vec_t vecs [7];

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // {in_ready, busy, done, spike_valid, spike, spike_count}
  function automatic logic [12:0] outVec();
    return {bus.in_ready, busy, done, spike_valid, spike, spike_count};
  endfunction

  // Run one whole train from a table entry and check it.
  task automatic applyStimulus(input int idx, input vec_t t);
    logic [15:0] pat;
    int          nvalid;
    int          cyc;
    int          gapc;
    bit          done_seen;
    bit          done_ok;
    bit          glitch;
    bit          strobed;
    pat = '0; nvalid = 0; cyc = 0; gapc = 0;
    done_seen = 0; done_ok = 0; glitch = 0;
    bus.in_value  = DW'(t.value);
    bus.threshold = DW'(t.thr);
    bus.num_steps = SW'(t.n);
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (done) begin
      done_seen = 1;
      done_ok   = (t.n == 0) && !spike_valid;
    end
    while (!done_seen && cyc < 500) begin
      gapc++;
      strobed = ((gapc % t.gap) == 0);
      step_en = strobed;
      tick();
      cyc++;
      step_en = 1'b0;
      if (spike_valid != strobed) glitch = 1;
      if (spike && !spike_valid) glitch = 1;
      if (!done && !busy) glitch = 1;
      if (spike_valid) begin
        if (nvalid < 16) pat[nvalid] = spike;
        nvalid++;
      end
      if (done) begin
        done_seen = 1;
        done_ok   = spike_valid && (nvalid == t.n);
      end
    end
    checkOutput($sformatf("vec%0d done_reached", idx), 32'(done_seen), 32'd1);
    checkOutput($sformatf("vec%0d spike_pattern", idx), 32'(pat), 32'(t.exp_pat));
    checkOutput($sformatf("vec%0d valid_pulses", idx), 32'(nvalid), 32'(t.n));
    checkOutput($sformatf("vec%0d done_coincident", idx), 32'(done_ok), 32'd1);
    checkOutput($sformatf("vec%0d strobe_timing", idx), 32'(glitch), 32'd0);
    checkOutput($sformatf("vec%0d spike_count", idx), 32'(spike_count), 32'(t.exp_count));
    checkOutput($sformatf("vec%0d ready_at_done", idx), 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput($sformatf("vec%0d idle_after", idx),
                32'({bus.in_ready, busy, done, spike_valid}), 32'b1000);
  endtask

  // Behavioural reference: spikes for step k are floor(k*v/thr)-floor((k-1)*v/thr).
  int          m_phase;
  int          m_thr, m_v, m_n, m_k, m_cnt;
  logic [12:0] m_exp;

  task automatic modelStep();
    bit m_done, m_sv, m_spike;
    int s, raw;
    m_done = 0; m_sv = 0; m_spike = 0;
    if (!rstn) begin
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid && !flush) begin
             raw   = int'(bus.threshold);
             m_thr = (raw < 1) ? 1 : raw;
             raw   = int'(bus.in_value);
             m_v   = (raw < 0) ? 0 : ((raw > m_thr) ? m_thr : raw);
             m_n   = int'(bus.num_steps);
             m_k   = 0;
             m_cnt = 0;
             if (m_n == 0) begin
               m_phase = 2;
               m_done  = 1;
             end else begin
               m_phase = 1;
             end
           end
        1: if (flush) begin
             m_phase = 0;
           end else if (step_en) begin
             m_k++;
             s = (m_k * m_v) / m_thr - ((m_k - 1) * m_v) / m_thr;
             m_sv    = 1;
             m_spike = (s != 0);
             m_cnt   = m_cnt + s;
             if (m_k == m_n) begin
               m_done  = 1;
               m_phase = 2;
             end
           end
        default: m_phase = 0;
      endcase
    end
    m_exp = {(m_phase == 0), (m_phase == 1), m_done, m_sv, m_spike, 8'(m_cnt)};
  endtask

  initial begin
    vecs[0] = '{3,   10, 10, 1, 16'h0248, 3};
    vecs[1] = '{-5,  10, 4,  1, 16'h0000, 0};
    vecs[2] = '{50,  10, 4,  1, 16'h000F, 4};
    vecs[3] = '{1,   0,  3,  1, 16'h0007, 3};
    vecs[4] = '{5,   10, 4,  3, 16'h000A, 2};
    vecs[5] = '{7,   16, 8,  1, 16'h0054, 3};
    vecs[6] = '{0,   -3, 5,  2, 16'h0000, 0};

    rstn = 1'b0; step_en = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_value = '0; bus.threshold = '0; bus.num_steps = '0;
    tick();
    tick();
    rstn = 1'b1;
    checkOutput("reset_state", 32'(outVec()), 32'({1'b1, 12'b0}));

    // Table-driven trains
    for (int i = 0; i < 7; i++) applyStimulus(i, vecs[i]);

    // Zero-length train
    bus.in_value = 16'sd5; bus.threshold = 16'sd10; bus.num_steps = 8'd0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checkOutput("zero_len_done", 32'({done, spike_valid, bus.in_ready, busy}), 32'b1000);
    tick();
    checkOutput("zero_len_ready", 32'({done, spike_valid, bus.in_ready, busy}), 32'b0010);

    // Flush together with the 4th step_en of a 10-step train
    bus.in_value = 16'sd5; bus.threshold = 16'sd10; bus.num_steps = 8'd10; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    step_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_outputs", 32'(outVec()), 32'({1'b1, 4'b0000, 8'd1}));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("flush_quiet", 32'(outVec()), 32'({1'b1, 4'b0000, 8'd1}));
    end
    step_en = 1'b0;

    // Reset mid-train overrides accept and step_en
    bus.in_value = 16'sd9; bus.threshold = 16'sd10; bus.num_steps = 8'd10; bus.in_valid = 1'b1;
    tick();
    step_en = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    tick();
    checkOutput("pre_reset_count", 32'(spike_count), 32'd1);
    rstn = 1'b0; bus.in_valid = 1'b1;
    tick();
    checkOutput("mid_train_reset", 32'(outVec()), 32'({1'b1, 12'b0}));
    rstn = 1'b1; bus.in_valid = 1'b0; step_en = 1'b0;
    tick();

    // Back-to-back triples with in_valid held high and step_en always on
    step_en = 1'b1;
    bus.in_value = 16'sd9; bus.threshold = 16'sd10; bus.num_steps = 8'd2; bus.in_valid = 1'b1;
    tick();
    checkOutput("b2b_first_accept", 32'({bus.in_ready, busy}), 32'b01);
    bus.num_steps = 8'd3;
    tick();
    checkOutput("b2b_a_step1", 32'(outVec()), 32'({5'b01010, 8'd0}));
    tick();
    checkOutput("b2b_a_done", 32'(outVec()), 32'({5'b00111, 8'd1}));
    tick();
    checkOutput("b2b_idle_gap", 32'({bus.in_ready, busy, done}), 32'b100);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("b2b_second_accept", 32'(outVec()), 32'({5'b01000, 8'd0}));
    tick();
    checkOutput("b2b_acc_restart", 32'(outVec()), 32'({5'b01010, 8'd0}));
    tick();
    tick();
    checkOutput("b2b_b_done", 32'(outVec()), 32'({5'b00111, 8'd2}));
    step_en = 1'b0;
    tick();

    // Randomized run against the reference model
    m_phase = 0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      int tmp;
      rstn    = (c == 0) ? 1'b0 : ($urandom_range(199) != 0);
      step_en = ($urandom_range(9) < 6);
      flush   = ($urandom_range(49) == 0);
      bus.in_valid = ($urandom_range(9) < 3);
      tmp = int'($urandom_range(80)) - 20;
      bus.in_value = DW'(tmp);
      tmp = int'($urandom_range(42)) - 2;
      bus.threshold = DW'(tmp);
      bus.num_steps = SW'($urandom_range(12));
      modelStep();
      tick();
      checkOutput($sformatf("random_cycle%0d", c), 32'(outVec()), 32'(m_exp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
